// File: rtl/dest_shift_ctrl.sv
// Sequencer for the ALU destination shift buffer: counts passes, drives buffer enables, holds a wavefront for writeback.
// Optional watchdog enabled by defining DEST_SHIFT_CTRL_TIMEOUT_EN (sets sticky timeout_err after TIMEOUT_CYC idle cycles in COLLECT).
module dest_shift_ctrl #(
  parameter int unsigned NUM_PASSES  = 4,
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_pass_valid,
  input  logic [TAG_W-1:0] alu_pass_tag,
  output logic             ctrl_ready,
  output logic             dest_buffer_wr_en,
  output logic             dest_buffer_shift_en,
  output logic [1:0]       pass_idx,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             flush,
  output logic             timeout_err
);

  localparam int unsigned      CNT_W     = (NUM_PASSES > 2) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NUM_PASSES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    WB_PEND = 2'b10
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] pass_cnt_r;
  logic             ctrl_ready_r;
  logic             wb_valid_r;
  logic [TAG_W-1:0] wb_tag_r;
  logic             accept_s;
  logic             timeout_hit_s;

  // Pass acceptance; a flush suppresses the buffer enables in its own cycle.
  always_comb begin
    accept_s = 1'b0;
    if (flush) begin
      accept_s = 1'b0;
    end else begin
      accept_s = alu_pass_valid & ctrl_ready_r;
    end
  end

  assign dest_buffer_wr_en    = accept_s;
  assign dest_buffer_shift_en = accept_s;
  assign ctrl_ready           = ctrl_ready_r;
  assign wb_valid             = wb_valid_r;
  assign wb_tag               = wb_tag_r;
  assign pass_idx             = 2'(pass_cnt_r);

`ifdef DEST_SHIFT_CTRL_TIMEOUT_EN
  localparam int unsigned      IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_cnt_r;
  logic              timeout_err_r;

  // Watchdog fires on the TIMEOUT_CYC-th consecutive idle cycle in COLLECT.
  always_comb begin
    timeout_hit_s = 1'b0;
    if ((state_r == COLLECT) && !flush && !accept_s && (idle_cnt_r == IDLE_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Idle-cycle counter and sticky error flag; only rst clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_r    <= IDLE_W'(0);
      timeout_err_r <= 1'b0;
    end else begin
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end
      if ((state_r != COLLECT) || flush || accept_s || timeout_hit_s) begin
        idle_cnt_r <= IDLE_W'(0);
      end else begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Main sequencer: pass counting, tag capture and writeback handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      pass_cnt_r   <= CNT_ZERO;
      ctrl_ready_r <= 1'b1;
      wb_valid_r   <= 1'b0;
      wb_tag_r     <= {TAG_W{1'b0}};
    end else if (flush) begin
      state_r      <= IDLE;
      pass_cnt_r   <= CNT_ZERO;
      ctrl_ready_r <= 1'b1;
      wb_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wb_tag_r   <= alu_pass_tag;
            pass_cnt_r <= CNT_ONE;
            state_r    <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept_s) begin
            if (pass_cnt_r == LAST_PASS) begin
              pass_cnt_r   <= CNT_ZERO;
              state_r      <= WB_PEND;
              wb_valid_r   <= 1'b1;
              ctrl_ready_r <= 1'b0;
            end else begin
              pass_cnt_r <= pass_cnt_r + CNT_ONE;
            end
          end else if (timeout_hit_s) begin
            pass_cnt_r <= CNT_ZERO;
            state_r    <= IDLE;
          end
        end
        WB_PEND: begin
          // Handshake cycle never accepts a pass; ready returns next cycle.
          if (wb_ready) begin
            state_r      <= IDLE;
            wb_valid_r   <= 1'b0;
            ctrl_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          pass_cnt_r   <= CNT_ZERO;
          ctrl_ready_r <= 1'b1;
          wb_valid_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dest_shift_ctrl.md
Name: dest_shift_ctrl

Overview:
Sequencer for the ALU destination shift buffer. The 16-lane ALU produces a 64-lane wavefront result in NUM_PASSES consecutive passes. This block drives the buffer's write/shift enables, counts passes, holds back the ALU while a completed wavefront waits for register-file writeback, and presents a valid/ready writeback handshake with the instruction tag. It sits between the ALU pass output and the VGPR/SGPR/VCC writeback ports.

Parameters:
NUM_PASSES, 4, ALU passes per wavefront (>=2)
TAG_W, 6, width of instruction tag carried with the wavefront
TIMEOUT_CYC, 64, watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
alu_pass_valid  in  1  ALU offers one 16-lane pass this cycle
alu_pass_tag  in  TAG_W  instruction tag; sampled on first pass only
ctrl_ready  out  1  block can accept a pass this cycle
dest_buffer_wr_en  out  1  load ALU pass into shift buffer
dest_buffer_shift_en  out  1  shift buffer by one pass slot
pass_idx  out  2  index of the next pass expected (0..NUM_PASSES-1)
wb_valid  out  1  full wavefront in buffer, writeback requested
wb_ready  in  1  register file accepts writeback
wb_tag  out  TAG_W  tag of the buffered wavefront
flush  in  1  synchronous abort of the current wavefront
timeout_err  out  1  sticky watchdog error (optional feature)

Behaviour:
- States: IDLE, COLLECT, WB_PEND. Reset → IDLE, pass_cnt=0, wb_tag=0, all outputs 0 except ctrl_ready=1.
- accept = alu_pass_valid & ctrl_ready. ctrl_ready = 1 in IDLE/COLLECT, 0 in WB_PEND.
- dest_buffer_wr_en = dest_buffer_shift_en = accept. Combinational, same cycle as the pass, zero latency. Both are 0 whenever accept=0.
- IDLE: on accept, capture alu_pass_tag into wb_tag and set pass_cnt=1 → COLLECT. If NUM_PASSES==1 were allowed this would skip COLLECT; it is forbidden by the parameter range.
- COLLECT: on accept, pass_cnt+1. When the accepted pass is pass NUM_PASSES-1: pass_cnt→0 and state→WB_PEND, with wb_valid=1 from the next cycle. Idle cycles (valid=0) hold state, no enables.
- WB_PEND: wb_valid=1 and wb_tag stable until wb_ready=1. On the wb_valid&wb_ready cycle → IDLE, and ctrl_ready returns the next cycle. No pass is accepted in the handshake cycle, so no back-to-back overlap.
- pass_idx = pass_cnt. It wraps to 0 after the last pass; the counter never exceeds NUM_PASSES-1.
- flush=1 (any state): next cycle → IDLE, pass_cnt=0, wb_valid=0. It takes priority over accept and wb_ready in the same cycle. Enables are forced to 0 in the flush cycle.
- rst asserted mid-wavefront: immediate return to reset values. The buffer contents are don't-care.
- alu_pass_tag is ignored on passes other than the first.

Optional Feature:
DEST_SHIFT_CTRL_TIMEOUT_EN
- Defined: an idle-cycle counter runs in COLLECT, cleared on each accept. If it reaches TIMEOUT_CYC with no accept, timeout_err is set (sticky until rst) and the state goes to IDLE with pass_cnt=0.
- Undefined: no counter; timeout_err is tied to 0; COLLECT waits indefinitely.

Test Plan:
- Reset then 4 consecutive valid passes, tag=0x2A → wr_en/shift_en high cycles 1-4, pass_idx 0,1,2,3, wb_valid=1 in cycle 5 with wb_tag=0x2A, ctrl_ready=0.
- WB_PEND with wb_ready low 3 cycles while alu_pass_valid=1 → no enables, wb_valid held; wb_ready=1 → IDLE next cycle, ctrl_ready=1.
- Passes with gaps (valid on cycles 1,3,4,7) → exactly 4 enable pulses on those cycles; wb_valid from cycle 8.
- flush asserted after pass 2 together with alu_pass_valid → no enable in that cycle, pass_idx=0 next cycle; a new 4-pass wavefront then completes normally with its own tag.
- rst low during COLLECT (pass_idx=2) → all outputs at reset values asynchronously; after release a full wavefront completes.
- With DEST_SHIFT_CTRL_TIMEOUT_EN and TIMEOUT_CYC=8: 1 pass then 8 idle cycles → timeout_err=1 (sticky), state IDLE; without the macro, timeout_err stays 0 and the pass resumes at pass_idx=1.
